md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/HI/LO width; legal values 8..64, even.
REQ-002 SHALL have parameter MULT_LAT, default 5: cycles busy for multiply ops; legal 1..31.
REQ-003 SHALL have parameter DIV_LAT, default 10: cycles busy for divide ops; legal 1..31.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  issue strobe; sampled only when busy low.
REQ-007 md_op  input  3  operation code (see REQ-013).
REQ-008 src_a  input  DATA_W  rs operand.
REQ-009 src_b  input  DATA_W  rt operand.
REQ-010 busy  output  1  registered; high while an operation is in flight.
REQ-011 hi  output  DATA_W  architectural HI register value.
REQ-012 lo  output  DATA_W  architectural LO register value.

Function
REQ-013 md_op encodings SHALL be: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
REQ-014 FSM SHALL have states IDLE and RUN; busy = (state == RUN).
REQ-015 IDLE, start high, op in {MULT,MULTU,DIV,DIVU,MADD,MADDU}: SHALL latch src_a, src_b, md_op, load counter with the op latency, go RUN next edge.
REQ-016 RUN: counter SHALL decrement each cycle; on the edge where counter reaches 1, HI/LO SHALL update and state SHALL return to IDLE; busy is thus high exactly LAT cycles.
REQ-017 hi/lo SHALL hold their previous values for the whole RUN period; no partial results visible.
REQ-018 MULT/MULTU: {hi,lo} SHALL be the 2*DATA_W-bit signed/unsigned product.
REQ-019 DIV/DIVU: lo = quotient, hi = remainder, signed ops truncate toward zero, remainder takes dividend sign.
REQ-020 Divide with src_b == 0 SHALL still occupy DIV_LAT cycles and SHALL leave hi/lo unchanged.
REQ-021 Signed most-negative / -1 SHALL give lo = most-negative, hi = 0.
REQ-022 MTHI/MTLO with start high in IDLE SHALL write src_a to hi/lo on the next edge, busy stays low, takes one cycle.
REQ-023 start while busy high SHALL be ignored entirely (core stalls on start|busy); no queueing.
REQ-024 Result completion and a new start in the same cycle: start is ignored (busy still high that cycle).
REQ-025 Arithmetic SHALL be computed from latched operands, not live inputs.

Reset
REQ-026 reset SHALL force state IDLE, busy 0, hi 0, lo 0, counter 0, latched operands 0.
REQ-027 reset asserted during RUN SHALL abort the op; no hi/lo update afterwards.
REQ-028 reset has priority over start in the same cycle.

Configuration
REQ-029 Macro MD_UNIT_MADD_EN: defined -> MADD/MADDU add the product to {hi,lo} (modulo 2^(2*DATA_W)) with MULT_LAT latency.
REQ-030 Undefined -> md_op 6/7 SHALL be treated as no-op: no state change, busy stays low, hi/lo unchanged.

Structure
REQ-031 Shared package md_pkg SHALL hold md_op encodings, FSM state enum, and the latency-counter width constant (5).
REQ-032 One sub-module md_divider (combinational signed/unsigned divide on DATA_W operands, returning quotient/remainder) is natural; multiply stays inline.

Verification
REQ-033 Default params, MULT a=0xFFFFFFFF b=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-035 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi/lo updated one cycle each, busy never high.
REQ-036 MULT issued, start DIV at cycle 2 and reset at cycle 3 -> DIV ignored; after reset busy=0, hi=lo=0, no late update.
REQ-037 With MD_UNIT_MADD_EN, hi=0, lo=0xFFFFFFFF, MADDU a=1 b=1 -> hi=1, lo=0; without macro same stimulus -> hi/lo unchanged, busy 0.
REQ-038 DATA_W=16, MULT_LAT=1: MULT 0x8000*0x8000 -> busy 1 cycle, hi=0x4000, lo=0x0000.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit:
// op encodings, FSM states and latency counter width.
package md_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic logic is_signed_op(md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider.
// Ports: dividend, divisor, is_signed -> quotient, remainder.
module md_divider #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              is_signed,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] q_u;
  logic [DATA_W-1:0] r_u;

  // Divide magnitudes, then restore signs: quotient truncates
  // toward zero, remainder follows the dividend. MIN/-1 wraps
  // back to MIN naturally.
  always_comb begin
    neg_a = is_signed & dividend[DATA_W-1];
    neg_b = is_signed & divisor[DATA_W-1];
    mag_a = neg_a ? -dividend : dividend;
    mag_b = neg_b ? -divisor : divisor;
    q_u   = '0;
    r_u   = '0;
    if (mag_b != '0) begin
      q_u = mag_a / mag_b;
      r_u = mag_a % mag_b;
    end
    quotient  = (neg_a ^ neg_b) ? -q_u : q_u;
    remainder = neg_a ? -r_u : r_u;
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit (MIPS-style).
// Ports: clk, reset, start, md_op, src_a, src_b -> busy, hi, lo.
// Macro MD_UNIT_MADD_EN enables MADD/MADDU accumulate ops.
module md_unit
  import md_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

`ifdef MD_UNIT_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  md_state_e           state;
  md_state_e           state_d;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    lat;
  md_op_e              op_in;
  md_op_e              op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   hi_d;
  logic [DATA_W-1:0]   lo_d;
  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] acc;
  logic                long_op;
  logic                issue;
  logic                done;
  logic                wr_res;

  assign op_in = md_op_e'(md_op);
  assign busy  = (state == RUN);

  always_comb begin
    long_op = 1'b0;
    lat     = '0;
    unique case (op_in)
      OP_MULT, OP_MULTU: begin
        long_op = 1'b1;
        lat     = CNT_W'(MULT_LAT);
      end
      OP_DIV, OP_DIVU: begin
        long_op = 1'b1;
        lat     = CNT_W'(DIV_LAT);
      end
      OP_MADD, OP_MADDU: begin
        long_op = MADD_EN;
        lat     = CNT_W'(MULT_LAT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && long_op) begin
          issue   = 1'b1;
          cnt_d   = lat;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  md_divider #(.DATA_W(DATA_W)) u_div (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (op_q == OP_DIV),
    .quotient  (quo),
    .remainder (rem)
  );

  // Operands are widened to 2*DATA_W so the low 2*DATA_W bits
  // of each product are exact.
  always_comb begin
    prod_s = {{DATA_W{a_q[DATA_W-1]}}, a_q}
           * {{DATA_W{b_q[DATA_W-1]}}, b_q};
    prod_u = {{DATA_W{1'b0}}, a_q}
           * {{DATA_W{1'b0}}, b_q};
    prod   = is_signed_op(op_q) ? prod_s : prod_u;
    acc    = {hi, lo} + prod;
  end

  always_comb begin
    wr_res = 1'b0;
    hi_d   = hi;
    lo_d   = lo;
    unique case (op_q)
      OP_MULT, OP_MULTU: begin
        {hi_d, lo_d} = prod;
        wr_res       = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        if (b_q != '0) begin
          hi_d   = rem;
          lo_d   = quo;
          wr_res = 1'b1;
        end
      end
      OP_MADD, OP_MADDU: begin
        {hi_d, lo_d} = acc;
        wr_res       = MADD_EN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_MULT;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (issue) begin
        a_q  <= src_a;
        b_q  <= src_b;
        op_q <= op_in;
      end
      if (done && wr_res) begin
        hi <= hi_d;
        lo <= lo_d;
      end
      if (state == IDLE && start) begin
        if (op_in == OP_MTHI) hi <= src_a;
        if (op_in == OP_MTLO) lo <= src_a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default 32-bit instance plus a
// DATA_W=16, MULT_LAT=1 instance.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic [15:0] hi16;
  logic [15:0] lo16;

  int errors = 0;
  int checks = 0;
  int n;
  int exp_n;

  always #5 clk = ~clk;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  md_unit #(.DATA_W(16), .MULT_LAT(1), .DIV_LAT(3)) dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .md_op (op16),
    .src_a (a16),
    .src_b (b16),
    .busy  (busy16),
    .hi    (hi16),
    .lo    (lo16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and count cycles with busy high (bounded).
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int cycles);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    src_a = 32'h5A5A_5A5A;
    src_b = 32'h0000_0003;
    cycles = 0;
    while (busy && cycles < 64) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    md_op   = 3'd0;
    src_a   = '0;
    src_b   = '0;
    start16 = 1'b0;
    op16    = 3'd0;
    a16     = '0;
    b16     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    // MULT with hold check on the first busy cycle
    start = 1'b1;
    md_op = 3'd0;
    src_a = 32'hFFFF_FFFF;
    src_b = 32'd2;
    tick();
    start = 1'b0;
    src_a = 32'd0;
    src_b = 32'd0;
    chk("mult_hold_hi", hi, 0);
    chk("mult_hold_lo", lo, 0);
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    chk("mult_lat", n, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    chk("multu_lat", n, 5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lat", n, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd0, n);
    chk("div0_lat", n, 10);
    chk("div0_hi", hi, 32'hFFFF_FFFF);
    chk("div0_lo", lo, 32'hFFFF_FFFD);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'h0000_0000);

    issue(3'd3, 32'd100, 32'd7, n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // MTHI then MTLO back to back
    start = 1'b1;
    md_op = 3'd4;
    src_a = 32'h1234_5678;
    tick();
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h1234_5678);
    md_op = 3'd5;
    src_a = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    chk("mtlo_busy", busy, 0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);

    // MADDU on hi=0, lo=all-ones
    start = 1'b1;
    md_op = 3'd4;
    src_a = 32'd0;
    tick();
    md_op = 3'd5;
    src_a = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    issue(3'd7, 32'd1, 32'd1, n);
`ifdef MD_UNIT_MADD_EN
    exp_n = 5;
    chk("maddu_lat", n, exp_n);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    exp_n = 0;
    chk("maddu_lat", n, exp_n);
    repeat (6) tick();
    chk("maddu_busy", busy, 0);
    chk("maddu_hi", hi, 32'd0);
    chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

    // MULT, DIV start while busy, then reset mid-run
    start = 1'b1;
    md_op = 3'd0;
    src_a = 32'd3;
    src_b = 32'd4;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    md_op = 3'd2;
    src_a = 32'd100;
    src_b = 32'd5;
    tick();
    chk("abort_busy_pre", busy, 1);
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (12) tick();
    chk("abort_late_busy", busy, 0);
    chk("abort_late_hi", hi, 0);
    chk("abort_late_lo", lo, 0);

    // start held high (as MTHI) through the run and completion
    start = 1'b1;
    md_op = 3'd0;
    src_a = 32'd2;
    src_b = 32'd3;
    tick();
    md_op = 3'd4;
    src_a = 32'h0000_DEAD;
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    start = 1'b0;
    chk("hold_lat", n, 5);
    chk("hold_hi", hi, 0);
    chk("hold_lo", lo, 32'd6);

    // 16-bit instance, single-cycle multiply
    start16 = 1'b1;
    op16    = 3'd0;
    a16     = 16'h8000;
    b16     = 16'h8000;
    tick();
    start16 = 1'b0;
    n = 0;
    while (busy16 && n < 64) begin
      n++;
      tick();
    end
    chk("w16_lat", n, 1);
    chk("w16_hi", hi16, 16'h4000);
    chk("w16_lo", lo16, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
